// File: rtl/pwm_wb_ctrl_if.sv
// Wishbone classic slave bundle between the Caravel user-project port and pwm_wb_ctrl.
// Signal names match the wrapper's wbs_* pins so hookup is one-to-one.
interface pwm_wb_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/pwm_wb_ctrl.sv
// PWM configuration block: firmware writes shadow period/duty, and each channel adopts
// them only at its period boundary (or at once while disabled) for glitch-free updates.
module pwm_wb_ctrl #(
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  pwm_wb_ctrl_if.slave            wb,
  input  logic [NUM_CH-1:0]       ch_period_end_i,
  output logic [NUM_CH-1:0]       ch_en_o,
  output logic [NUM_CH-1:0]       ch_load_o,
  output logic [NUM_CH*WIDTH-1:0] ch_period_o,
  output logic [NUM_CH*WIDTH-1:0] ch_duty_o
);

  localparam logic [5:0] SH_FIRST = 6'd4;
  localparam logic [5:0] SH_END   = 6'(4 + 2 * NUM_CH);

  logic [NUM_CH-1:0] ctrl, pending, done, load_q;
  logic [WIDTH-1:0]  period_sh  [NUM_CH];
  logic [WIDTH-1:0]  duty_sh    [NUM_CH];
  logic [WIDTH-1:0]  act_period [NUM_CH];
  logic [WIDTH-1:0]  act_duty   [NUM_CH];
  logic              ack_q;
  logic [31:0]       dat_q;

  logic              decoded, req, wr, is_sh;
  logic [5:0]        word, sh_idx;
  logic [4:0]        sh_ch;
  logic [31:0]       rdata, wmerge;
  logic [NUM_CH-1:0] ctrl_next, ctrl_rise, upd_set, done_clr, commit;
  logic              unused_bits;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    return res;
  endfunction

  // The !ack term stops a request held through its ack cycle from being serviced twice.
  assign decoded = (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req     = wb.wbs_cyc_i & wb.wbs_stb_i & decoded & ~ack_q;
  assign wr      = req & wb.wbs_we_i;
  assign word    = wb.wbs_adr_i[7:2];
  assign is_sh   = (word >= SH_FIRST) && (word < SH_END);
  assign sh_idx  = word - SH_FIRST;
  assign sh_ch   = sh_idx[5:1];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rdata = '0;
    if (word == 6'd0)      rdata[NUM_CH-1:0] = ctrl;
    else if (word == 6'd1) rdata[NUM_CH-1:0] = pending;
    else if (word == 6'd2) rdata[NUM_CH-1:0] = done;
    else if (is_sh) begin
      for (int n = 0; n < NUM_CH; n++)
        if (sh_ch == 5'(n)) rdata[WIDTH-1:0] = sh_idx[0] ? duty_sh[n] : period_sh[n];
    end
  end

  // The read mux doubles as the old value for byte-masked writes.
  assign wmerge    = byte_merge(rdata, wb.wbs_dat_i, wb.wbs_sel_i);
  assign ctrl_next = (wr && word == 6'd0) ? wmerge[NUM_CH-1:0] : ctrl;
  assign ctrl_rise = ctrl_next & ~ctrl;
  assign upd_set   = (wr && word == 6'd1 && wb.wbs_sel_i[0]) ? wb.wbs_dat_i[NUM_CH-1:0] : '0;
  assign done_clr  = (wr && word == 6'd2 && wb.wbs_sel_i[0]) ? wb.wbs_dat_i[NUM_CH-1:0] : '0;
  assign commit    = pending & (ch_period_end_i | ~ctrl);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      ctrl    <= '0;
      pending <= '0;
      done    <= '0;
      load_q  <= '0;
      // NOTE: the shadow/active arrays are plain flops that firmware may read before
      // writing, so they are cleared here like any other register, not left as RAM.
      for (int n = 0; n < NUM_CH; n++) begin
        period_sh[n]  <= '0;
        duty_sh[n]    <= '0;
        act_period[n] <= '0;
        act_duty[n]   <= '0;
      end
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values, which is what
      // makes "commit uses the old shadow" and "set beats W1C" fall out naturally.
      ack_q   <= req;
      dat_q   <= (req && !wb.wbs_we_i) ? rdata : '0;
      ctrl    <= ctrl_next;
      pending <= (pending & ~commit) | upd_set;
      done    <= (done & ~done_clr) | commit;
      load_q  <= commit | ctrl_rise;
      for (int n = 0; n < NUM_CH; n++) begin
        if (wr && is_sh && sh_ch == 5'(n)) begin
          if (sh_idx[0]) duty_sh[n]   <= wmerge[WIDTH-1:0];
          else           period_sh[n] <= wmerge[WIDTH-1:0];
        end
        if (commit[n]) begin
          act_period[n] <= period_sh[n];
          act_duty[n]   <= (duty_sh[n] > period_sh[n]) ? period_sh[n] : duty_sh[n];
        end
      end
    end
  end

  always_comb begin
    ch_en_o     = '0;
    ch_period_o = '0;
    ch_duty_o   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      ch_en_o[n]                 = ctrl[n] && (act_period[n] != '0);
      ch_period_o[n*WIDTH +: WIDTH] = act_period[n];
      ch_duty_o[n*WIDTH +: WIDTH]   = act_duty[n];
    end
  end

  assign ch_load_o    = load_q;
  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign unused_bits  = ^{wb.wbs_adr_i[1:0], wmerge};

endmodule

// File: tb/tb_pwm_wb_ctrl.sv
// Directed bench for pwm_wb_ctrl: a register-access vector table, then hand-built
// sequences for commit timing, clamping and same-cycle interactions.
module tb_pwm_wb_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  pend_end = '0;
  logic [3:0]  ch_en, ch_load;
  logic [63:0] ch_period, ch_duty;
  int          checks = 0;
  int          failures = 0;

  pwm_wb_ctrl_if wb ();

  pwm_wb_ctrl dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .wb              (wb),
    .ch_period_end_i (pend_end),
    .ch_en_o         (ch_en),
    .ch_load_o       (ch_load),
    .ch_period_o     (ch_period),
    .ch_duty_o       (ch_duty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [11:0] off;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        exp_ack;
    logic [31:0] exp_rdat;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  function automatic logic [15:0] per(input int n);
    return ch_period[n*16 +: 16];
  endfunction

  function automatic logic [15:0] dty(input int n);
    return ch_duty[n*16 +: 16];
  endfunction

  task automatic bus(input logic we, input logic [11:0] off, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rd,
                     output logic acked, output int lat);
    if (wb.wbs_ack_o) step();
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = sel;
    wb.wbs_adr_i = BASE + 32'(off);
    wb.wbs_dat_i = dat;
    rd = '0;
    acked = 1'b0;
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (wb.wbs_ack_o) begin
        acked = 1'b1;
        lat = i;
        rd = wb.wbs_dat_o;
        break;
      end
    end
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] dat);
    logic [31:0] rd_v;
    logic        ak;
    int          lt;
    bus(1'b1, off, dat, 4'hF, rd_v, ak, lt);
    check($sformatf("wr_ack_%0h", off), 64'(ak), 64'd1);
  endtask

  task automatic rd(input logic [11:0] off, input logic [31:0] exp);
    logic [31:0] rd_v;
    logic        ak;
    int          lt;
    bus(1'b0, off, 32'h0, 4'hF, rd_v, ak, lt);
    check($sformatf("rd_ack_%0h", off), 64'(ak), 64'd1);
    check($sformatf("rd_dat_%0h", off), 64'(rd_v), 64'(exp));
  endtask

  // Single-cycle write request with ch_period_end_i pulsed in the same sampling cycle.
  task automatic xend(input logic [11:0] off, input logic [31:0] dat, input logic [3:0] mask);
    if (wb.wbs_ack_o) step();
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b1;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = BASE + 32'(off);
    wb.wbs_dat_i = dat;
    pend_end     = mask;
    step();
    pend_end     = '0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    check($sformatf("xend_ack_%0h", off), 64'(wb.wbs_ack_o), 64'd1);
  endtask

  task automatic pulse_end(input logic [3:0] mask);
    pend_end = mask;
    step();
    pend_end = '0;
  endtask

  initial begin
    logic [31:0] rd_v;
    logic        ak;
    int          lt;

    vecs[0]  = '{1'b0, 12'h000, 32'h0,         4'hF, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, 12'h004, 32'h0,         4'hF, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, 12'h008, 32'h0,         4'hF, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 12'h010, 32'h0,         4'hF, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 12'h02C, 32'h0,         4'hF, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 12'h020, 32'hFFFF_ABCD, 4'hF, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 12'h020, 32'h0,         4'hF, 1'b1, 32'h0000_ABCD};
    vecs[7]  = '{1'b1, 12'h020, 32'h0000_1234, 4'h1, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 12'h020, 32'h0,         4'hF, 1'b1, 32'h0000_AB34};
    vecs[9]  = '{1'b1, 12'h024, 32'h0000_5566, 4'h2, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 12'h024, 32'h0,         4'hF, 1'b1, 32'h0000_5500};
    vecs[11] = '{1'b0, 12'h00C, 32'h0,         4'hF, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 12'h00C, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 12'h00C, 32'h0,         4'hF, 1'b1, 32'h0};
    vecs[14] = '{1'b0, 12'h100, 32'h0,         4'hF, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 12'h100, 32'h1234,      4'hF, 1'b0, 32'h0};
    vecs[16] = '{1'b1, 12'h000, 32'hFFFF_FFF0, 4'hF, 1'b1, 32'h0};
    vecs[17] = '{1'b0, 12'h000, 32'h0,         4'hF, 1'b1, 32'h0};

    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = '0;
    wb.wbs_dat_i = '0;

    // Reset state
    idle(3);
    check("rst_en", 64'(ch_en), 64'h0);
    check("rst_load", 64'(ch_load), 64'h0);
    check("rst_period", ch_period, 64'h0);
    check("rst_duty", ch_duty, 64'h0);
    check("rst_ack", 64'(wb.wbs_ack_o), 64'h0);
    check("rst_dat", 64'(wb.wbs_dat_o), 64'h0);
    rst = 1'b0;

    // Register access table
    for (int i = 0; i < 18; i++) begin
      bus(vecs[i].we, vecs[i].off, vecs[i].wdat, vecs[i].sel, rd_v, ak, lt);
      check($sformatf("vec%0d_ack", i), 64'(ak), 64'(vecs[i].exp_ack));
      if (vecs[i].exp_ack) begin
        check($sformatf("vec%0d_latency", i), 64'(lt), 64'd1);
        if (!vecs[i].we) check($sformatf("vec%0d_rdat", i), 64'(rd_v), 64'(vecs[i].exp_rdat));
      end
    end

    // Disabled channel 0 commits the cycle after pending is set
    wr(12'h010, 32'd100);
    wr(12'h014, 32'd40);
    wr(12'h004, 32'h1);
    step();
    check("ch0_load", 64'(ch_load), 64'h1);
    check("ch0_period", 64'(per(0)), 64'd100);
    check("ch0_duty", 64'(dty(0)), 64'd40);
    step();
    check("ch0_load_end", 64'(ch_load), 64'h0);
    rd(12'h008, 32'h1);
    rd(12'h004, 32'h0);
    wr(12'h008, 32'h1);
    rd(12'h008, 32'h0);

    // Channel 1: enable with period 200, then a reconfiguration waits for period end
    wr(12'h018, 32'd200);
    wr(12'h01C, 32'd100);
    wr(12'h004, 32'h2);
    idle(3);
    wr(12'h000, 32'h2);
    check("ch1_ctrl_rise_load", 64'(ch_load), 64'h2);
    check("ch1_en", 64'(ch_en), 64'h2);
    step();
    check("ch1_ctrl_load_end", 64'(ch_load), 64'h0);
    wr(12'h018, 32'd50);
    wr(12'h01C, 32'd25);
    wr(12'h004, 32'h2);
    idle(4);
    check("ch1_hold_period", 64'(per(1)), 64'd200);
    check("ch1_hold_duty", 64'(dty(1)), 64'd100);
    check("ch1_hold_load", 64'(ch_load), 64'h0);
    rd(12'h004, 32'h2);
    pulse_end(4'h2);
    check("ch1_commit_load", 64'(ch_load), 64'h2);
    check("ch1_commit_period", 64'(per(1)), 64'd50);
    check("ch1_commit_duty", 64'(dty(1)), 64'd25);
    step();
    check("ch1_commit_load_end", 64'(ch_load), 64'h0);
    rd(12'h004, 32'h0);

    // Channel 3: duty clamps to period; zero period keeps an enabled channel off
    wr(12'h028, 32'd255);
    wr(12'h02C, 32'd300);
    wr(12'h004, 32'h8);
    step();
    check("clamp_period", 64'(per(3)), 64'd255);
    check("clamp_duty", 64'(dty(3)), 64'd255);
    wr(12'h028, 32'd0);
    wr(12'h000, 32'hA);
    check("ch3_en_on", 64'(ch_en), 64'hA);
    wr(12'h004, 32'h8);
    idle(2);
    check("ch3_wait_period", 64'(per(3)), 64'd255);
    pulse_end(4'h8);
    check("zero_period", 64'(per(3)), 64'd0);
    check("zero_duty", 64'(dty(3)), 64'd0);
    check("zero_period_en", 64'(ch_en), 64'h2);

    // UPDATE coincident with period end: commit deferred to the next period end
    wr(12'h018, 32'd77);
    wr(12'h01C, 32'd33);
    idle(2);
    xend(12'h004, 32'h2, 4'h2);
    check("late_upd_load", 64'(ch_load), 64'h0);
    check("late_upd_period", 64'(per(1)), 64'd50);
    rd(12'h004, 32'h2);
    pulse_end(4'h2);
    check("late_upd_commit_load", 64'(ch_load), 64'h2);
    check("late_upd_commit_period", 64'(per(1)), 64'd77);
    check("late_upd_commit_duty", 64'(dty(1)), 64'd33);

    // Shadow write coincident with commit: old shadow is committed
    wr(12'h018, 32'd88);
    wr(12'h004, 32'h2);
    idle(2);
    xend(12'h018, 32'd99, 4'h2);
    check("old_shadow_load", 64'(ch_load), 64'h2);
    check("old_shadow_period", 64'(per(1)), 64'd88);
    rd(12'h018, 32'd99);

    // UPDATE coincident with commit: commit happens and pending stays set
    wr(12'h004, 32'h2);
    idle(2);
    xend(12'h004, 32'h2, 4'h2);
    check("upd_commit_load", 64'(ch_load), 64'h2);
    check("upd_commit_period", 64'(per(1)), 64'd99);
    rd(12'h004, 32'h2);

    // DONE set and W1C in the same cycle: set wins
    wr(12'h008, 32'hF);
    rd(12'h008, 32'h0);
    xend(12'h008, 32'h2, 4'h2);
    check("done_race_load", 64'(ch_load), 64'h2);
    rd(12'h008, 32'h2);
    rd(12'h004, 32'h0);

    // Reset while a read request is being sampled
    idle(1);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = BASE;
    rst = 1'b1;
    step();
    check("rst_mid_ack", 64'(wb.wbs_ack_o), 64'h0);
    rst = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    check("rst_mid_en", 64'(ch_en), 64'h0);
    check("rst_mid_load", 64'(ch_load), 64'h0);
    check("rst_mid_period", ch_period, 64'h0);
    check("rst_mid_duty", ch_duty, 64'h0);
    step();
    check("rst_mid_ack_after", 64'(wb.wbs_ack_o), 64'h0);
    rd(12'h000, 32'h0);
    rd(12'h01C, 32'h0);
    rd(12'h008, 32'h0);
    rd(12'h004, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
